// File: rtl/rom_sample_streamer.sv
// rom_sample_streamer: Avalon-MM ROM read master that streams each 32-bit word as two 16-bit samples
module rom_sample_streamer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int SAMPLE_W = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  output logic [ADDR_W-1:0]   rom_address,
  output logic                rom_chipselect,
  output logic                rom_clken,
  input  logic [DATA_W-1:0]   rom_readdata,
  output logic [SAMPLE_W-1:0] src_data,
  output logic                src_valid,
  input  logic                src_ready,
  output logic                busy,
  output logic                done
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W+1:0] DEPTH = (PTR_W+2)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_nxt;
  logic inflight, abort, half, loop_q;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] fifo_count;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0] count_q, remain;
  logic start_ok, zero_start, abort_req, issue, last, wr, accept, pop, drain_done;
  assign busy = state != IDLE;
  assign start_ok = start && !stop && state == IDLE && word_count != '0;
  assign zero_start = start && !stop && state == IDLE && word_count == '0;
  assign abort_req = stop && busy && !abort;
  assign issue = reset_n && state == FETCH && ({1'b0, fifo_count} + (PTR_W+2)'(inflight)) < DEPTH;
  assign rom_chipselect = issue;
  assign last = remain == (ADDR_W+1)'(1);
  assign wr = inflight && !abort && !abort_req;
  assign src_valid = fifo_count != '0;
  assign src_data = !src_valid ? '0 : half ? mem[rd_ptr][DATA_W-1:SAMPLE_W] : mem[rd_ptr][SAMPLE_W-1:0];
  assign accept = src_valid && src_ready;
  assign pop = accept && half;
  assign drain_done = state == DRAIN && !abort && !inflight &&
                      (fifo_count == '0 || (fifo_count == (PTR_W+1)'(1) && pop));
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = abort_req ? (issue ? DRAIN : IDLE) :
                start_ok ? FETCH :
                (issue && last && !loop_q) ? DRAIN :
                (abort || drain_done) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rom_clken <= 1'b0;
      done <= 1'b0;
      inflight <= 1'b0;
      abort <= 1'b0;
      rom_address <= '0;
      base_q <= '0;
      count_q <= '0;
      remain <= '0;
      loop_q <= 1'b0;
    end else begin
      rom_clken <= 1'b1;
      done <= zero_start || (drain_done && !abort_req);
      inflight <= issue;
      abort <= abort_req && issue;
      if (start_ok) begin
        rom_address <= base_addr;
        base_q <= base_addr;
        count_q <= word_count;
        remain <= word_count;
        loop_q <= loop_en;
      end else if (issue) begin
        rom_address <= (last && loop_q) ? base_q : rom_address + ADDR_W'(1);
        remain <= last ? count_q : remain - (ADDR_W+1)'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n || abort_req) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      half <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (accept) half <= !half;
      fifo_count <= fifo_count + (PTR_W+1)'(wr) - (PTR_W+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= rom_readdata;
  end
endmodule

// File: tb/tb_rom_sample_streamer.sv
// tb_rom_sample_streamer: randomized self-checking bench against a transaction-level playback model
module tb_rom_sample_streamer;
  localparam int AW = 9, DW = 32, SW = 16, FD = 4;
  logic clk = 0, reset_n = 0, start = 0, stop = 0, loop_en = 0, src_ready = 0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] word_count = '0;
  logic [AW-1:0] rom_address;
  logic rom_chipselect, rom_clken, src_valid, busy, done;
  logic [DW-1:0] rom_readdata = '0;
  logic [SW-1:0] src_data;
  logic [DW-1:0] rom [512];
  int checks = 0, failures = 0, cyc = 0, ready_mode = 0;
  logic [AW-1:0] addr_q[$], exp_addr[$];
  logic [SW-1:0] samp_q[$], exp_samp[$];
  int done_cnt, done_bad, busy_seen, first_cs, first_valid, gap, fetched, acc_n, stop_seen, start_cyc, done_cyc;
  logic prev_valid = 0, prev_ready = 0, prev_stop = 0;
  logic [SW-1:0] prev_data = '0;

  rom_sample_streamer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop_en(loop_en),
    .base_addr(base_addr), .word_count(word_count), .rom_address(rom_address),
    .rom_chipselect(rom_chipselect), .rom_clken(rom_clken), .rom_readdata(rom_readdata),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_readdata <= rom[rom_address];
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial forever begin
    @(posedge clk);
    #1;
    src_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ($urandom_range(0, 99) < 60) : 1'b0;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (rom_chipselect) begin
        if (first_cs < 0) first_cs = cyc;
        addr_q.push_back(rom_address);
        fetched++;
        check("credit", 32'(fetched - acc_n / 2 <= FD), 1);
      end
      if (src_valid && first_valid < 0) first_valid = cyc;
      if (first_valid >= 0 && !src_valid && stop_seen == 0) gap++;
      if (prev_valid && !prev_ready && !prev_stop) begin
        check("hold_valid", 32'(src_valid), 1);
        check("hold_data", 32'(src_data), 32'(prev_data));
      end
      if (src_valid && src_ready) begin
        samp_q.push_back(src_data);
        acc_n++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy) done_bad++;
      end
      if (busy) busy_seen++;
      if (stop) stop_seen = 1;
    end
    prev_valid = reset_n && src_valid;
    prev_ready = src_ready;
    prev_stop = stop;
    prev_data = src_data;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    addr_q.delete(); samp_q.delete(); exp_addr.delete(); exp_samp.delete();
    done_cnt = 0; done_bad = 0; busy_seen = 0; gap = 0; fetched = 0; acc_n = 0; stop_seen = 0;
    first_cs = -1; first_valid = -1; done_cyc = -1;
  endtask

  task automatic build_exp(int base, int cnt, bit lp, int n_words);
    for (int i = 0; i < n_words; i++) begin
      int a;
      a = (base + (lp ? i % cnt : i)) % 512;
      exp_addr.push_back(AW'(a));
      exp_samp.push_back(rom[a][15:0]);
      exp_samp.push_back(rom[a][31:16]);
    end
  endtask

  task automatic cmp(string tag, bit prefix);
    int bad_a = 0, bad_s = 0;
    if (!prefix) begin
      check({tag, "_addr_len"}, addr_q.size(), exp_addr.size());
      check({tag, "_samp_len"}, samp_q.size(), exp_samp.size());
    end
    for (int i = 0; i < addr_q.size() && i < exp_addr.size(); i++) if (addr_q[i] !== exp_addr[i]) bad_a++;
    for (int i = 0; i < samp_q.size() && i < exp_samp.size(); i++) if (samp_q[i] !== exp_samp[i]) bad_s++;
    check({tag, "_addr_bad"}, bad_a, 0);
    check({tag, "_samp_bad"}, bad_s, 0);
  endtask

  task automatic do_start(logic [AW-1:0] base, int cnt, bit lp, bit record);
    base_addr = base;
    word_count = (AW+1)'(cnt);
    loop_en = lp;
    start = 1;
    if (record) start_cyc = cyc;
    tick;
    start = 0;
  endtask

  task automatic do_stop;
    stop = 1;
    tick;
    stop = 0;
    @(negedge clk);
    check("stop_cs", 32'(rom_chipselect), 0);
    check("stop_valid", 32'(src_valid), 0);
    @(negedge clk);
    check("stop_idle", 32'(busy), 0);
  endtask

  task automatic wait_done(int bound);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == 0) check("done_timeout", 0, 1);
  endtask

  task automatic check_reset;
    check("rst_cs", 32'(rom_chipselect), 0);
    check("rst_clken", 32'(rom_clken), 0);
    check("rst_valid", 32'(src_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_addr", 32'(rom_address), 0);
    check("rst_data", 32'(src_data), 0);
  endtask

  task automatic run_oneshot(logic [AW-1:0] base, int cnt, int mode, bit restart);
    clear_mon;
    ready_mode = mode;
    build_exp(base, cnt, 0, cnt);
    do_start(base, cnt, 0, 1);
    check("busy_after_start", 32'(busy), 1);
    if (restart && cnt >= 8) begin
      tick;
      tick;
      do_start(AW'($urandom), 5, 1, 0);
    end
    wait_done(cnt * 12 + 40);
    repeat (3) tick;
    check("done_pulses", done_cnt, 1);
    check("busy_at_done", done_bad, 0);
    check("busy_idle", 32'(busy), 0);
    check("start_to_cs", first_cs - start_cyc, 1);
    check("cs_to_valid", first_valid - first_cs, 2);
    cmp("oneshot", 0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = $urandom;
    clear_mon;
    repeat (2) tick;
    @(negedge clk);
    check_reset;
    tick;
    reset_n = 1;
    tick;
    check("clken_after_reset", 32'(rom_clken), 1);

    run_oneshot(9'h010, 3, 0, 0);
    run_oneshot(9'h1FE, 4, 1, 0);

    clear_mon;
    ready_mode = 0;
    build_exp(9'h020, 2, 1, 200);
    do_start(9'h020, 2, 1, 1);
    repeat (19) tick;
    do_stop;
    repeat (3) tick;
    cmp("loop", 1);
    check("loop_min_samples", 32'(samp_q.size() >= 15), 1);
    check("loop_gap", gap, 0);
    check("loop_no_done", done_cnt, 0);

    clear_mon;
    begin
      logic [AW-1:0] b;
      b = AW'($urandom);
      ready_mode = 0;
      build_exp(b, 16, 0, 16);
      do_start(b, 16, 0, 1);
      repeat (4) tick;
      ready_mode = 2;
      repeat (30) tick;
      check("stall_bound", 32'(fetched - acc_n / 2 <= FD), 1);
      ready_mode = 0;
      wait_done(300);
      repeat (2) tick;
      check("stall_done", done_cnt, 1);
      cmp("stall", 0);
    end

    clear_mon;
    begin
      logic [AW-1:0] b;
      b = AW'($urandom);
      ready_mode = 1;
      build_exp(b, 100, 0, 100);
      do_start(b, 100, 0, 1);
      tick;
      tick;
      do_stop;
      repeat (4) tick;
      check("abort_no_done", done_cnt, 0);
      cmp("abort", 1);
    end

    clear_mon;
    base_addr = AW'($urandom);
    word_count = 10;
    start = 1;
    stop = 1;
    tick;
    start = 0;
    stop = 0;
    repeat (4) tick;
    check("ss_no_cs", addr_q.size(), 0);
    check("ss_busy", busy_seen, 0);
    check("ss_done", done_cnt, 0);

    for (int r = 0; r < 10; r++)
      run_oneshot(AW'($urandom_range(0, 511)), $urandom_range(1, 48), $urandom_range(0, 1), r % 3 == 0);
    run_oneshot(AW'($urandom), 512, 0, 0);
    run_oneshot(9'h1FF, 1, 1, 0);

    clear_mon;
    ready_mode = 0;
    do_start(AW'($urandom), 100, 0, 1);
    repeat (5) tick;
    reset_n = 0;
    tick;
    @(negedge clk);
    check_reset;
    tick;
    reset_n = 1;
    tick;
    clear_mon;
    do_start(AW'($urandom), 0, 0, 1);
    repeat (6) tick;
    check("zero_no_cs", addr_q.size(), 0);
    check("zero_done", done_cnt, 1);
    check("zero_done_lat", done_cyc - start_cyc, 1);
    check("zero_busy", busy_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
